// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath.
//   state_t        : job FSM states shared by the serial adder/subtractor
//   DEFAULT_WIDTH  : default operand width
//   cnt_width()    : bit-counter width for a given operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must index bits 0..w-1; keep at least one bit so a 1-bit
  // datapath still gets a legal vector.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin.
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow ripples in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes {0,A} - {0,B} one bit per clock, LSB first,
// using a single full-subtractor cell. Same go/busy/done handshake and timing
// as the serial adder so a controller can issue either job interchangeably.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   A, B  : minuend / subtrahend, sampled only at job start
//   go    : start request, rising-edge triggered
//   diff  : WIDTH+1 bit two's-complement result, updated only at job end
//   busy  : high while bits are being processed
//   done  : one-cycle pulse in the cycle after diff was updated
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             go,
  output logic [WIDTH:0]   diff,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_reg;
  state_t             state_next;
  logic               go_q_reg;
  logic [WIDTH-1:0]   a_sr_reg;
  logic [WIDTH-1:0]   b_sr_reg;
  logic [WIDTH-1:0]   r_sr_reg;
  logic               borrow_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH:0]     diff_reg;

  logic start;
  logic last_bit;
  logic d_bit;
  logic bout_bit;

  // Holding go high never retriggers: go_q_reg follows go every cycle.
  assign start    = go & ~go_q_reg;
  assign last_bit = (cnt_reg == LAST_BIT);

  full_subtractor u_cell (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .bin  (borrow_reg),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; go edges outside IDLE are dropped, not queued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Datapath: edge detector, operand/result shift registers, borrow, counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q_reg   <= 1'b0;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      r_sr_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
    end else begin
      go_q_reg <= go;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg   <= A;
            b_sr_reg   <= B;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          r_sr_reg   <= {d_bit, r_sr_reg[WIDTH-1:1]};
          borrow_reg <= bout_bit;
          cnt_reg    <= cnt_reg + 1'b1;
          // The last bit bypasses r_sr so diff is complete on this edge;
          // the final borrow is the sign bit of the WIDTH+1 bit result.
          if (last_bit) begin
            diff_reg <= {bout_bit, d_bit, r_sr_reg[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_reg;
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             go  = 1'b0;
  logic [WIDTH-1:0] A   = '0;
  logic [WIDTH-1:0] B   = '0;
  logic [WIDTH:0]   diff;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .go   (go),
    .diff (diff),
    .busy (busy),
    .done (done)
  );

  // Reference: plain integer subtraction truncated to WIDTH+1 bits.
  function automatic logic [WIDTH:0] ref_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int v;
    v = int'(a) - int'(b);
    return (WIDTH+1)'(v);
  endfunction

  // Stimulus only: issues one job from a negedge with go low, then observes
  // WIDTH+6 cycles. lat = cycle index (1 = after start edge) of first done.
  task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH:0] d, output int busy_n,
                         output int done_n, output int lat);
    A = a; B = b; go = 1'b1;
    busy_n = 0; done_n = 0; lat = -1; d = '0;
    for (int c = 1; c <= WIDTH + 6; c++) begin
      @(negedge clk);
      if (c == 1) go = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin lat = c; d = diff; end
      end
    end
  endtask

  task automatic test_reset();
    logic [WIDTH:0] d;
    int done_n, lat;
    rst = 1'b0; go = 1'b1; A = 8'd3; B = 8'd1;
    #12;
    checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff: got %h expected %h", diff, 9'h000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    // go already high when reset releases: the first edge must start a job.
    @(negedge clk); rst = 1'b1;
    done_n = 0; lat = -1; d = '0;
    for (int c = 1; c <= WIDTH + 6; c++) begin
      @(negedge clk);
      if (c == 1) go = 1'b0;
      if (done) begin
        done_n++;
        if (lat < 0) begin lat = c; d = diff; end
      end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL reset_release_done_count: got %0d expected 1", done_n); end
    checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL reset_release_latency: got %0d expected %0d", lat, WIDTH + 1); end
    checks++; if (d !== 9'h002) begin errors++; $display("FAIL reset_release_diff: got %h expected %h", d, 9'h002); end
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] a_tab [5] = '{8'd7, 8'd15, 8'd255, 8'd0, 8'd0};
    logic [WIDTH-1:0] b_tab [5] = '{8'd15, 8'd7, 8'd0, 8'd255, 8'd0};
    logic [WIDTH:0]   e_tab [5] = '{9'h1F8, 9'h008, 9'h0FF, 9'h101, 9'h000};
    logic [WIDTH:0] d;
    int busy_n, done_n, lat;
    for (int i = 0; i < 5; i++) begin
      run_job(a_tab[i], b_tab[i], d, busy_n, done_n, lat);
      $display("job A=%0d B=%0d diff=%h busy=%0d done=%0d lat=%0d", a_tab[i], b_tab[i], d, busy_n, done_n, lat);
      checks++; if (d !== e_tab[i]) begin errors++; $display("FAIL vec%0d_diff: got %h expected %h", i, d, e_tab[i]); end
      checks++; if (busy_n !== WIDTH) begin errors++; $display("FAIL vec%0d_busy_cycles: got %0d expected %0d", i, busy_n, WIDTH); end
      checks++; if (done_n !== 1) begin errors++; $display("FAIL vec%0d_done_count: got %0d expected 1", i, done_n); end
      checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, WIDTH + 1); end
    end
  endtask

  task automatic test_go_held();
    logic [WIDTH:0] d;
    int busy_n, done_n, lat;
    A = 8'd9; B = 8'd4; go = 1'b1;
    done_n = 0; d = '0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 30) go = 1'b0;
      if (done) begin done_n++; d = diff; end
    end
    $display("job held-go A=9 B=4 diff=%h done=%0d", d, done_n);
    checks++; if (done_n !== 1) begin errors++; $display("FAIL held_go_done_count: got %0d expected 1", done_n); end
    checks++; if (d !== 9'h005) begin errors++; $display("FAIL held_go_diff: got %h expected %h", d, 9'h005); end
    run_job(8'd5, 8'd6, d, busy_n, done_n, lat);
    $display("job A=5 B=6 diff=%h done=%0d", d, done_n);
    checks++; if (d !== 9'h1FF) begin errors++; $display("FAIL rego_diff: got %h expected %h", d, 9'h1FF); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL rego_done_count: got %0d expected 1", done_n); end
  endtask

  task automatic test_ignore_retrigger();
    logic [WIDTH:0] d;
    int done_n, lat;
    A = 8'd200; B = 8'd100; go = 1'b1;
    done_n = 0; lat = -1; d = '0;
    for (int c = 1; c <= WIDTH + 12; c++) begin
      @(negedge clk);
      if (c == 1) go = 1'b0;
      if (c == 3) begin A = 8'd1; B = 8'd2; go = 1'b1; end
      if (c == 4) go = 1'b0;
      if (done) begin
        done_n++;
        if (lat < 0) begin lat = c; d = diff; end
      end
    end
    $display("job retrigger A=200 B=100 diff=%h done=%0d lat=%0d", d, done_n, lat);
    checks++; if (d !== 9'h064) begin errors++; $display("FAIL retrig_diff: got %h expected %h", d, 9'h064); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL retrig_done_count: got %0d expected 1", done_n); end
    checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL retrig_latency: got %0d expected %0d", lat, WIDTH + 1); end
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH:0] d;
    int busy_n, done_n, lat;
    // diff is non-zero (100) from the previous job, so clearing is observable.
    A = 8'd50; B = 8'd20; go = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) go = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++; if (diff !== '0) begin errors++; $display("FAIL midrst_diff: got %h expected %h", diff, 9'h000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    @(negedge clk); rst = 1'b1;
    done_n = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", done_n); end
    run_job(8'd50, 8'd20, d, busy_n, done_n, lat);
    $display("job after reset A=50 B=20 diff=%h done=%0d", d, done_n);
    checks++; if (d !== 9'h01E) begin errors++; $display("FAIL midrst_fresh_diff: got %h expected %h", d, 9'h01E); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL midrst_fresh_done_count: got %0d expected 1", done_n); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0] d, exp;
    int busy_n, done_n, lat;
    for (int i = 0; i < 1000; i++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(0, 255));
      exp = ref_diff(a, b);
      run_job(a, b, d, busy_n, done_n, lat);
      $display("rand%0d A=%0d B=%0d diff=%h exp=%h", i, a, b, d, exp);
      checks++; if (d !== exp) begin errors++; $display("FAIL rand%0d_diff: got %h expected %h", i, d, exp); end
      checks++; if (done_n !== 1 || lat !== WIDTH + 1) begin
        errors++; $display("FAIL rand%0d_done: got count %0d lat %0d expected count 1 lat %0d", i, done_n, lat, WIDTH + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_vectors();
    test_go_held();
    test_ignore_retrigger();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor built around one reusable full-subtractor cell, computing A − B one bit per clock, LSB first. It is the inverse-operation companion to the serial adder DataPath and shares its parallel-in/parallel-out, `go`-started handshake. It sits alongside the adder in the serial arithmetic datapath, so a controller can issue add or subtract jobs with identical timing.

## Interface
- `WIDTH`, default 8, operand width in bits; result is `WIDTH+1` bits.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `A`  input  WIDTH  minuend; sampled only at job start.
- `B`  input  WIDTH  subtrahend; sampled only at job start.
- `go`  input  1  start request; rising-edge triggered (see Operation).
- `diff`  output  WIDTH+1  result register; two's-complement value of {0,A} − {0,B}.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse when `diff` has just been updated.

## Operation
- States: IDLE, RUN, DONE.
- `go_q` is a registered copy of `go`. A start is `go & ~go_q`, sampled at a clock edge.
- IDLE, on start: load `A`/`B` into shift registers `a_sr`/`b_sr`, clear `borrow` and bit counter `cnt`, then go to RUN. Otherwise stay in IDLE.
- RUN, each edge:
  - `d = a0 ^ b0 ^ borrow`
  - `bout = (~a0 & b0) | (~(a0 ^ b0) & borrow)`
  - Shift `a_sr`/`b_sr` right by one. Shift `d` into the MSB of result shift register `r_sr`. Set `borrow <= bout` and `cnt <= cnt + 1`.
- On the edge that processes bit `WIDTH−1`:
  - `diff <= {bout, d, r_sr[WIDTH-1:1]}`, so the final borrow is the sign bit.
  - Go to DONE.
- DONE: unconditionally go to IDLE on the next edge.
- `busy = (state == RUN)`; `done = (state == DONE)`.
- `diff` holds its value until the next job completes. Partial results are never visible on `diff`.
- Width rule: with 8-bit operands the range is −255..+255, and `diff` is exact in 9-bit two's complement. No overflow is possible.

## Timing
- Reset (rst low, asynchronous): state=IDLE; `diff`=0, `busy`=0, `done`=0; `go_q`=0, `borrow`=0, `cnt`=0, all shift registers=0.
- Start edge E0 → RUN during cycles E0..E8. Bits are processed at edges E1..E8 (WIDTH edges).
- `diff` is valid and `done`=1 in the cycle following E8. The state is IDLE again after E9.
- Latency from the start edge to `done`: WIDTH+1 cycles. Minimum repeat interval: WIDTH+2 cycles.
- A `go` rising edge during RUN or DONE is ignored. It is not queued.
- Holding `go` high does not retrigger, because `go_q` stays high. A new job needs `go` low for at least one sampled edge.
- `A`/`B` changes after E0 have no effect on the running job.
- Reset asserted mid-RUN aborts the job and clears `diff` to 0. If `go` is high when `rst` releases, the first edge sees `go_q`=0 and starts a job.

## Structure
- Package `serial_arith_pkg`:
  - `state_t` enum {IDLE, RUN, DONE}
  - default `WIDTH` localparam
  - counter width `$clog2(WIDTH)`
- One natural sub-module, `full_subtractor`: combinational 1-bit cell with inputs (a, b, bin) and outputs (d, bout), instantiated once.
- The top level holds the FSM, counter, three shift registers, the `diff` register, and the `go` edge detector.

## Test plan
- A=7, B=15, `go` pulse → after 9 cycles `done`=1 for one cycle and `diff`=9'h1F8 (−8); `busy` high for exactly 8 cycles.
- A=15, B=7 → `diff`=9'h008. A=255, B=0 → 9'h0FF. A=0, B=255 → 9'h101. A=0, B=0 → 9'h000.
- `go` held high for 300 ns from start → exactly one job and one `done` pulse. Lower `go`, then raise it with A=5, B=6 → `diff`=9'h1FF.
- Second `go` edge at cycle 3 of RUN, with A/B changed → ignored; result reflects the original operands; no extra `done`.
- Reset pulsed low at cycle 4 of RUN → outputs 0 immediately (asynchronous), state IDLE, no `done` pulse afterward. A fresh job then completes correctly.
- Random sweep of 1000 operand pairs → `diff` equals $signed({1'b0,A}) − $signed({1'b0,B}).
